// File: rtl/fixed_pkg.sv
// Shared arithmetic helpers for the fixed-point add/subtract pipeline.
// Operands travel MAX_BITS wide (sign-extended) so one function serves every BITS.
package fixed_pkg;

  localparam int MAX_BITS = 64;

  typedef logic [MAX_BITS-1:0] word_t;
  typedef logic [MAX_BITS:0]   wide_t;

  function automatic word_t FIXED_MAX(input int bits);
    return (word_t'(1) << (bits - 1)) - word_t'(1);
  endfunction

  function automatic word_t FIXED_MIN(input int bits);
    return ~FIXED_MAX(bits);
  endfunction

  // Returns {ovf, result}; only result[bits-1:0] is meaningful to the caller.
  function automatic wide_t sat_addsub(input word_t a, input word_t b, input logic op_sub,
                                       input int bits, input logic saturate);
    wide_t s;
    logic  ovf;
    word_t res;
    s = op_sub ? ({a[MAX_BITS-1], a} - {b[MAX_BITS-1], b})
               : ({a[MAX_BITS-1], a} + {b[MAX_BITS-1], b});
    // The exact sum fits in bits+1; overflow when its top two bits disagree.
    ovf = ^(2'(s >> (bits - 1)));
    if (saturate && ovf) begin
      res = s[MAX_BITS] ? FIXED_MIN(bits) : FIXED_MAX(bits);
    end else begin
      res = s[MAX_BITS-1:0];
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/fixed_pipe_stage.sv
// One delay slice of the add/sub pipeline: valid, data and overflow registers.
module fixed_pipe_stage #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            valid_i,
  input  logic [BITS-1:0] data_i,
  input  logic            ovf_i,
  output logic            valid_o,
  output logic [BITS-1:0] data_o,
  output logic            ovf_o
);

  logic            valid_q;
  logic [BITS-1:0] data_q;
  logic            ovf_q;

  // Payload only loads with a real beat, so bubbles leave the last data in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
        ovf_q  <= ovf_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/fixed_addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with optional saturation,
// per-beat and sticky overflow, and whole-pipe valid/ready stalling.
module fixed_addsub_pipe
  import fixed_pkg::*;
#(
  parameter int               BITS        = 8,
  parameter logic [8*16-1:0]  PRECISION   = "FIXED_4_4",
  parameter int               PIPE_STAGES = 2,
  parameter int               SATURATE    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_sub,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c,
  output logic            ovf,
  output logic            ovf_sticky,
  input  logic            ovf_clr
);

  logic                              adv;
  logic [PIPE_STAGES-1:0]            v_s;
  logic [PIPE_STAGES-1:0][BITS-1:0]  c_s;
  logic [PIPE_STAGES-1:0]            o_s;
  word_t                             a_ext;
  word_t                             b_ext;
  logic [BITS-1:0]                   c1_d;
  logic                              ovf1_d;
  logic                              v1_q;
  logic [BITS-1:0]                   c1_q;
  logic                              o1_q;
  logic                              sticky_q;
  logic                              sticky_d;
  logic                              unused_prec;

  // The format tag only labels the stream; the binary point never moves.
  assign unused_prec = ^PRECISION;

  assign adv      = !v_s[PIPE_STAGES-1] || out_ready;
  assign in_ready = adv;

  assign a_ext = word_t'($signed(a));
  assign b_ext = word_t'($signed(b));

  always_comb begin
    c1_d   = BITS'(sat_addsub(a_ext, b_ext, op_sub, BITS, SATURATE != 0));
    ovf1_d = 1'(sat_addsub(a_ext, b_ext, op_sub, BITS, SATURATE != 0) >> MAX_BITS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      c1_q <= '0;
      o1_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        c1_q <= c1_d;
        o1_q <= ovf1_d;
      end
    end
  end

  assign v_s[0] = v1_q;
  assign c_s[0] = c1_q;
  assign o_s[0] = o1_q;

  for (genvar i = 1; i < PIPE_STAGES; i++) begin : g_stage
    fixed_pipe_stage #(.BITS(BITS)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .valid_i(v_s[i-1]),
      .data_i (c_s[i-1]),
      .ovf_i  (o_s[i-1]),
      .valid_o(v_s[i]),
      .data_o (c_s[i]),
      .ovf_o  (o_s[i])
    );
  end

  assign out_valid = v_s[PIPE_STAGES-1];
  assign c         = c_s[PIPE_STAGES-1];
  assign ovf       = o_s[PIPE_STAGES-1];

  // A set on the same cycle as a clear wins.
  assign sticky_d = (sticky_q && !ovf_clr) || (out_valid && out_ready && ovf);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// Bench for fixed_addsub_pipe: vector table, reset/sticky sequences and a
// scoreboarded stream with random output backpressure.
module tb_fixed_addsub_pipe;

  localparam int PS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       op_sub = 1'b0;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       in_ready, out_valid, ovf, ovf_sticky;
  logic [7:0] c;
  logic       in_ready_w, out_valid_w, ovf_w, ovf_sticky_w;
  logic [7:0] c_w;

  always #5 clk = ~clk;

  fixed_addsub_pipe #(.BITS(8), .PRECISION("FIXED_4_4"), .PIPE_STAGES(PS), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  fixed_addsub_pipe #(.BITS(8), .PRECISION("FIXED_4_4"), .PIPE_STAGES(PS), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready), .c(c_w), .ovf(ovf_w),
    .ovf_sticky(ovf_sticky_w), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [7:0] c;
    logic       ovf;
    logic [7:0] cw;
  } exp_t;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       ovf;
    logic [7:0] cw;
  } vec_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         n_out = 0;
  bit         mon_en = 0;
  bit         stall_prev = 0;
  logic [7:0] c_prev;
  logic       ovf_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [7:0] x, input logic [7:0] y);
    int   sx, sy, s;
    exp_t e;
    sx = int'($signed(x));
    sy = int'($signed(y));
    s  = op ? sx - sy : sx + sy;
    e.ovf = (s > 127) || (s < -128);
    e.cw  = s[7:0];
    e.c   = !e.ovf ? s[7:0] : ((s > 0) ? 8'h7f : 8'h80);
    return e;
  endfunction

  // Scoreboard and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("in_ready_adv", in_ready, !out_valid || out_ready);
      chk("in_ready_wrap_inst", in_ready_w, in_ready);
      if (stall_prev) begin
        chk("stall_hold_valid", out_valid, 1'b1);
        chk("stall_hold_c", c, c_prev);
        chk("stall_hold_ovf", ovf, ovf_prev);
      end
      stall_prev = out_valid && !out_ready;
      c_prev     = c;
      ovf_prev   = ovf;
      if (in_valid && in_ready) sb_q.push_back(model(op_sub, a, b));
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_out: got c=%0h with no beat outstanding", c);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_c", c, e.c);
          chk("sb_ovf", ovf, e.ovf);
          chk("sb_c_wrap", c_w, e.cw);
          chk("sb_ovf_wrap", ovf_w, e.ovf);
        end
      end
    end else begin
      stall_prev = 0;
    end
  end

  // Starts and ends at posedge+2; leaves the result on the outputs, not yet transferred.
  task automatic run_beat(input string tag, input logic op, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] ec, input logic eo, input logic [7:0] ecw);
    int n;
    op_sub = op; a = x; b = y; in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no out_valid after %0d cycles, required within %0d", tag, n, PS);
    end else begin
      chk({tag, "_latency"}, n, PS);
      chk({tag, "_c"}, c, ec);
      chk({tag, "_ovf"}, ovf, eo);
      chk({tag, "_c_wrap"}, c_w, ecw);
      chk({tag, "_ovf_wrap"}, ovf_w, eo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t vt[10];
    int   n0, guard;
    bit   acc;

    vt[0] = '{1'b0, 8'h30, 8'h18, 8'h48, 1'b0, 8'h48};
    vt[1] = '{1'b0, 8'h70, 8'h20, 8'h7f, 1'b1, 8'h90};
    vt[2] = '{1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 8'h7f};
    vt[3] = '{1'b1, 8'h00, 8'h80, 8'h7f, 1'b1, 8'h80};
    vt[4] = '{1'b0, 8'h80, 8'h80, 8'h80, 1'b1, 8'h00};
    vt[5] = '{1'b1, 8'h10, 8'h30, 8'he0, 1'b0, 8'he0};
    vt[6] = '{1'b0, 8'h7f, 8'h80, 8'hff, 1'b0, 8'hff};
    vt[7] = '{1'b1, 8'h7f, 8'hff, 8'h7f, 1'b1, 8'h80};
    vt[8] = '{1'b0, 8'hf0, 8'hf8, 8'he8, 1'b0, 8'he8};
    vt[9] = '{1'b1, 8'h80, 8'h7f, 8'h80, 1'b1, 8'h01};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_c", c, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_sticky", ovf_sticky, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    rst_n = 1'b1;
    mon_en = 1;
    out_ready = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 10; i++) begin
      run_beat($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].ovf, vt[i].cw);
    end
    @(posedge clk); #2;
    chk("table_sticky", ovf_sticky, 1'b1);
    chk("table_drained", out_valid, 1'b0);

    // Reset with two beats stalled in flight.
    out_ready = 1'b0;
    op_sub = 1'b0; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #2;
    a = 8'h70; b = 8'h20;
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("stall_out_valid", out_valid, 1'b1);
    chk("stall_in_ready", in_ready, 1'b0);
    @(posedge clk); #2;
    chk("stall_c_frozen", c, 8'h30);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_sticky", ovf_sticky, 1'b0);
    chk("flush_c", c, 8'h00);
    chk("flush_out_valid_wrap", out_valid_w, 1'b0);
    sb_q.delete();
    @(posedge clk); #2;
    chk("flush_no_partial", out_valid, 1'b0);
    out_ready = 1'b1;
    run_beat("post_rst", 1'b0, 8'h20, 8'h08, 8'h28, 1'b0, 8'h28);
    @(posedge clk); #2;

    // Sticky clear racing a set, then a lone clear.
    run_beat("clr_race", 1'b0, 8'h70, 8'h20, 8'h7f, 1'b1, 8'h90);
    chk("sticky_before_xfer", ovf_sticky, 1'b0);
    ovf_clr = 1'b1;
    @(posedge clk); #2;
    ovf_clr = 1'b0;
    chk("sticky_set_wins", ovf_sticky, 1'b1);
    ovf_clr = 1'b1;
    @(posedge clk); #2;
    ovf_clr = 1'b0;
    chk("sticky_cleared", ovf_sticky, 1'b0);
    run_beat("no_ovf", 1'b0, 8'h30, 8'h18, 8'h48, 1'b0, 8'h48);
    @(posedge clk); #2;
    chk("sticky_stays_clear", ovf_sticky, 1'b0);

    // Stream of 8 beats with random output backpressure.
    n0 = n_out;
    for (int k = 0; k < 8; k++) begin
      op_sub = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      in_valid = 1'b1;
      acc = 0;
      guard = 0;
      while (!acc && guard < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        acc = in_ready;
        @(posedge clk); #2;
        guard++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL stream_accept_timeout: got no in_ready for beat %0d, required within 100 cycles", k);
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while ((out_valid || sb_q.size() != 0) && guard < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
      guard++;
    end
    chk("stream_count", n_out - n0, 8);
    chk("stream_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fixed_addsub_pipe.md
# fixed_addsub_pipe

Parametrised pipelined fixed-point adder/subtractor for the Precision/Fixed library. It is the successor to the single-cycle subtract block and adds:
- a per-beat add/subtract select;
- optional saturation with a per-beat overflow flag and a sticky overflow status;
- configurable pipeline depth with full valid/ready backpressure.

It sits between fixed-point producers and consumers (filters, accumulators) wherever streams must stall without losing data.

## Interface
- BITS, default 8: total word width, two's complement; legal 2..64.
- PRECISION, default "FIXED_4_4": format tag carried for the library; does not change arithmetic, because the binary point is identical on all operands.
- PIPE_STAGES, default 2: register stages from input to output; legal 1..4.
- SATURATE, default 1: 1 clamps on overflow, 0 wraps modulo 2^BITS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the input beat this cycle
- op_sub  in  1  0: c = a + b; 1: c = a - b
- a  in  BITS  signed operand
- b  in  BITS  signed operand
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts the output beat
- c  out  BITS  signed result
- ovf  out  1  overflow occurred on this output beat (also asserted in wrap mode)
- ovf_sticky  out  1  latched OR of every ovf transferred out since reset or clear
- ovf_clr  in  1  clears ovf_sticky

## Operation
- Transfer rule: a beat moves in when in_valid && in_ready, and moves out when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. All stages shift together when adv=1, so there are no bubble-collapsing registers. in_ready = adv, combinational.
- Stage 1 arithmetic:
  - Sign-extend a and b to BITS+1 bits.
  - Form s = a + b or s = a - b.
  - ovf1 = s[BITS] ^ s[BITS-1].
  - If SATURATE=1 and ovf1: positive overflow (s[BITS]=0) gives 2^(BITS-1)-1; negative overflow gives -2^(BITS-1).
  - Otherwise the result is s[BITS-1:0].
  - Stage 1 registers the result, ovf1 and the valid bit.
- Stages 2..PIPE_STAGES are pure delay registers (data, ovf, valid), gated by adv.
- Within each stage, data and ovf registers load only when adv=1 and the incoming valid=1. A stage's valid bit loads the incoming valid whenever adv=1.
- ovf_sticky:
  - Set on the cycle a beat with ovf=1 transfers out.
  - Cleared by ovf_clr. If clear and set occur in the same cycle, set wins.
- Fixed-point semantics: add and subtract need no rescaling. FRAC bits are implied by PRECISION and pass through unchanged.
- Corner case: a - b with b = -2^(BITS-1) is handled by the extended width with no special path. Example: 0 - 0x80 = +128, which saturates to 0x7F with ovf=1.

## Timing
- Latency is PIPE_STAGES cycles from the accepting clock edge to out_valid, when out_ready is held high.
- Throughput is one beat per cycle while out_ready=1.
- Holding out_ready=0 with out_valid=1 freezes c, ovf and out_valid until the beat transfers. in_ready=0 during that time.
- Reset value of every output: out_valid=0, c=0, ovf=0, ovf_sticky=0. in_ready=1 after reset because adv=1.
- Reset mid-operation flushes all in-flight beats: every valid bit is 0 on the next cycle and no partial beat is emitted.
- A stalled input beat (in_valid=1, in_ready=0) is the producer's responsibility to hold stable. The block does not sample it.

## Structure
- Package fixed_pkg:
  - function sat_addsub(a, b, op_sub) returning {ovf, result}, parametrised through BITS-wide typedefs;
  - constants FIXED_MAX(BITS) and FIXED_MIN(BITS).
- Sub-module fixed_pipe_stage: one valid/data/ovf register slice with enable and synchronous reset. It is instantiated PIPE_STAGES-1 times through a generate loop.
- Top level holds the stage-1 arithmetic, the advance logic and the sticky flag.

## Test plan
All scenarios use BITS=8, "FIXED_4_4", PIPE_STAGES=2 unless stated.
1. Add 0x30 + 0x18 (3.0 + 1.5), out_ready=1 -> c=0x48, ovf=0, out_valid exactly 2 cycles after acceptance.
2. SATURATE=1:
   - 0x70 + 0x20 -> c=0x7F, ovf=1, ovf_sticky=1.
   - Subtract 0x80 - 0x01 -> c=0x80, ovf=1.
   - 0x00 - 0x80 -> c=0x7F, ovf=1.
3. SATURATE=0: 0x70 + 0x20 -> c=0x90, ovf=1.
4. Back-to-back stream of 8 beats with out_ready toggled pseudo-randomly -> all 8 results in order, none dropped or duplicated; in_ready mirrors adv every cycle.
5. rst_n low for 1 cycle while 2 beats are in flight -> out_valid=0, ovf_sticky=0 next cycle; a fresh beat then emerges with normal latency.
6. ovf_clr pulsed on the same cycle an overflowing beat transfers -> ovf_sticky stays 1; a later ovf_clr alone -> 0.
